// File: rtl/crypto1_extend.sv
// -----------------------------------------------------------------------------
// crypto1_extend
//
// Purpose:
//   Extends each 20-bit Crypto1 filter-window candidate by one bit b in {0,1}.
//   For each b, the shifted window W = {cand[18:0], b} is passed through the
//   Crypto1 filter function f. If f(W) equals the keystream bit captured with
//   the candidate, {cand, b} is pushed into a small first-word-fall-through
//   survivor FIFO. After the candidate flagged as last, the block waits for
//   the FIFO to drain and then raises DONE until the next reset.
//
// Ports:
//   CLK        in   rising-edge clock
//   RESETn     in   synchronous active-low reset
//   KS_BIT     in   keystream bit, sampled together with the candidate
//   IN_DATA    in   [19:0] candidate filter window
//   IN_LAST    in   final candidate of the run
//   IN_VALID   in   candidate present
//   IN_READY   out  block accepts a candidate (IDLE and not DONE)
//   OUT_DATA   out  [20:0] survivor {cand, b} at FIFO head
//   OUT_VALID  out  FIFO not empty
//   OUT_READY  in   consumer pops the head survivor
//   DONE       out  run complete, sticky until reset
//   IN_COUNT   out  [15:0] accepted candidates (CRYPTO1_EXTEND_STATS_EN only)
//   OUT_COUNT  out  [15:0] FIFO pushes         (CRYPTO1_EXTEND_STATS_EN only)
//
// Configuration macro:
//   CRYPTO1_EXTEND_STATS_EN  adds the saturating IN_COUNT/OUT_COUNT counters.
// -----------------------------------------------------------------------------
module crypto1_extend #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        KS_BIT,
    input  logic [19:0] IN_DATA,
    input  logic        IN_LAST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [20:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
`ifdef CRYPTO1_EXTEND_STATS_EN
    output logic [15:0] IN_COUNT,
    output logic [15:0] OUT_COUNT,
`endif
    output logic        DONE
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [15:0] FA_TBL  = 16'h9E98;
    localparam logic [15:0] FB_TBL  = 16'hB48E;
    localparam logic [31:0] NLF_TBL = 32'hEC57E80A;

    // Crypto1 two-layer filter: five nibble lookups form the index into NLF.
    function automatic logic filt(input logic [19:0] x);
        logic [4:0] idx;
        idx = {FA_TBL[x[19:16]], FB_TBL[x[15:12]], FA_TBL[x[11:8]],
               FA_TBL[x[7:4]],   FB_TBL[x[3:0]]};
        return NLF_TBL[idx];
    endfunction

    typedef enum logic [1:0] {IDLE, EVAL0, EVAL1, FLUSH} state_t;

    state_t            state_q;
    logic [19:0]       cand_q;
    logic              last_q;
    logic              ks_q;
    logic              done_q;
    logic              in_ready_q;

    logic [20:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              evaluating;
    logic              eval_b;
    logic [19:0]       window;
    logic              want_push;
    logic              fifo_full;
    logic              fifo_nonempty;
    logic              pop;
    logic              push;
    logic              stall;
    logic              accept;

    assign evaluating    = (state_q == EVAL0) || (state_q == EVAL1);
    assign eval_b        = (state_q == EVAL1);
    assign window        = {cand_q[18:0], eval_b};
    assign want_push     = evaluating && (filt(window) == ks_q);
    assign fifo_full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty && OUT_READY;
    // A full FIFO still takes the push when the head is popped this cycle.
    assign push          = want_push && (!fifo_full || pop);
    assign stall         = want_push && !push;
    assign accept        = in_ready_q && IN_VALID;

    assign IN_READY  = in_ready_q;
    assign DONE      = done_q;
    assign OUT_VALID = fifo_nonempty;
    assign OUT_DATA  = mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q    <= IDLE;
            cand_q     <= '0;
            last_q     <= 1'b0;
            ks_q       <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cand_q     <= IN_DATA;
                        last_q     <= IN_LAST;
                        ks_q       <= KS_BIT;
                        in_ready_q <= 1'b0;
                        state_q    <= EVAL0;
                    end else begin
                        // Covers the first cycle after reset release.
                        in_ready_q <= 1'b1;
                    end
                end
                EVAL0: begin
                    if (!stall) begin
                        state_q <= EVAL1;
                    end
                end
                EVAL1: begin
                    if (!stall) begin
                        if (last_q) begin
                            state_q <= FLUSH;
                        end else begin
                            state_q    <= IDLE;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Terminal state: DONE stays high until reset.
                    if (!fifo_nonempty) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Survivor storage; contents are don't-care while the slot is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cand_q, eval_b};
        end
    end

`ifdef CRYPTO1_EXTEND_STATS_EN
    logic [15:0] in_count_q;
    logic [15:0] out_count_q;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            in_count_q  <= '0;
            out_count_q <= '0;
        end else begin
            if (accept && (in_count_q != 16'hFFFF)) begin
                in_count_q <= in_count_q + 16'd1;
            end
            if (push && (out_count_q != 16'hFFFF)) begin
                out_count_q <= out_count_q + 16'd1;
            end
        end
    end

    assign IN_COUNT  = in_count_q;
    assign OUT_COUNT = out_count_q;
`endif

endmodule

// File: doc/crypto1_extend.md
CRYPTO1_EXTEND -- requirements
Module: crypto1_extend

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, output survivor FIFO depth in entries (power of two, at least 2).
REQ-002 SHALL provide these ports, one per line:
- CLK  in  1  rising-edge clock.
- RESETn  in  1  synchronous, active-low reset.
- KS_BIT  in  1  keystream bit every candidate is checked against.
- IN_DATA  in  20  20-bit candidate filter window from the enumerator.
- IN_LAST  in  1  marks the final candidate of the run.
- IN_VALID  in  1  candidate present.
- IN_READY  out  1  block accepts the candidate.
- OUT_DATA  out  21  surviving extended candidate {cand, b}.
- OUT_VALID  out  1  survivor present at the FIFO head.
- OUT_READY  in  1  consumer takes the survivor.
- DONE  out  1  run complete.

Function
REQ-003 SHALL define f(x[19:0]) = NLFc[{Fa(x[19:16]), Fb(x[15:12]), Fa(x[11:8]), Fa(x[7:4]), Fb(x[3:0])}].
- Fa = bit n of 0x9E98.
- Fb = bit n of 0xB48E.
- NLFc = bit n of 0xEC57E80A.
- n is the nibble value or 5-bit index.
REQ-004 SHALL use FSM states IDLE, EVAL0, EVAL1, FLUSH.
REQ-005 SHALL drive IN_READY=1 only in IDLE with DONE=0; a transfer occurs when IN_VALID&&IN_READY on a clock edge.
REQ-006 On transfer, SHALL capture IN_DATA, IN_LAST and KS_BIT into internal registers and move to EVAL0; KS_BIT changes after capture SHALL NOT affect that candidate.
REQ-007 EVAL0 SHALL form W={cand[18:0],1'b0}.
- If f(W)==ks, SHALL push {cand,1'b0} to the FIFO.
- Then SHALL move to EVAL1.
REQ-008 EVAL1 SHALL do the same with b=1.
- If the captured last flag is 0, SHALL then move to IDLE; otherwise to FLUSH.
REQ-009 If a push is required and the FIFO is full, SHALL hold the EVAL state with no push until a slot frees; a pop and push in the same cycle while full SHALL both succeed.
REQ-010 A non-matching evaluation SHALL advance without a push and never stall.
REQ-011 Minimum throughput SHALL be one candidate per 3 cycles (IDLE, EVAL0, EVAL1).
REQ-012 FIFO SHALL be first-word-fall-through.
- OUT_DATA is valid the cycle after a push.
- Pop occurs on OUT_VALID&&OUT_READY.
- Order SHALL be preserved, b=0 before b=1.
- Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 FLUSH SHALL wait until the FIFO is empty, then set DONE=1.
- DONE stays set and IN_READY stays 0 until reset.
REQ-014 OUT_DATA SHALL be don't-care when OUT_VALID=0.

Reset
REQ-015 While RESETn=0 at a clock edge:
- State SHALL go to IDLE and the FIFO to empty.
- IN_READY, OUT_VALID, DONE SHALL be 0, with IN_READY rising the cycle after release.
- Internal candidate registers SHALL clear to 0.
REQ-016 Reset mid-run SHALL discard the in-flight candidate and all FIFO contents with no further output.

Configuration
REQ-017 With macro CRYPTO1_EXTEND_STATS_EN defined, SHALL add output ports IN_COUNT[15:0] and OUT_COUNT[15:0].
- IN_COUNT counts accepted candidates; OUT_COUNT counts FIFO pushes.
- Both are reset to 0 and saturate at 0xFFFF.
REQ-018 Without CRYPTO1_EXTEND_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-019 After reset:
- IN_DATA=0x00000, KS_BIT=0, IN_LAST=1, OUT_READY=1.
- Exactly one survivor 0x000000, since f(0)=0 and f(1)=1.
- DONE=1 after the FIFO drains.
REQ-020 Same stimulus as REQ-019 but KS_BIT=1 -> exactly one survivor 0x000001.
REQ-021 OUT_READY=0, FIFO_DEPTH=4, stream of enumerator candidates that all match:
- IN_READY stalls once 4 entries are held.
- Releasing OUT_READY drains the entries in order with no loss or duplication.
REQ-022 Random 1000 candidates, random OUT_READY:
- Survivor set equals a reference model computing f per REQ-003.
- With STATS_EN, IN_COUNT=1000 and OUT_COUNT equals the survivor count.
REQ-023 Assert RESETn=0 in EVAL1 with 3 entries queued -> next cycle OUT_VALID=0, DONE=0; IN_READY=1 the cycle after release.
